// File: rtl/stream_fifo_thresh.sv
// rtl/stream_fifo_thresh.sv - single-clock valid/ready FIFO with arbitrary depth, fall-through and fill thresholds
module stream_fifo_thresh #(
    parameter type T            = logic,
    parameter int  DEPTH        = 8,
    parameter bit  FALL_THROUGH = 1'b0,
    parameter int  ALM_FULL_TH  = DEPTH - 1,
    parameter int  ALM_EMPTY_TH = 1,
    localparam int IdxWidth     = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
    localparam int CntWidth     = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  T                    data_i,
    input  logic                valid_i,
    output logic                ready_o,
    output T                    data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [CntWidth-1:0] usage_o,
    output logic                alm_full_o,
    output logic                alm_empty_o
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("stream_fifo_thresh: DEPTH must be >= 2");
    end
    if (ALM_FULL_TH < 1 || ALM_FULL_TH > DEPTH) begin : g_bad_full_th
        $error("stream_fifo_thresh: ALM_FULL_TH must be in 1..DEPTH");
    end
    if (ALM_EMPTY_TH < 0 || ALM_EMPTY_TH > DEPTH - 1) begin : g_bad_empty_th
        $error("stream_fifo_thresh: ALM_EMPTY_TH must be in 0..DEPTH-1");
    end

    T                    storage [DEPTH];
    logic [IdxWidth-1:0] wptr_q;
    logic [IdxWidth-1:0] rptr_q;
    logic [CntWidth-1:0] usage_q;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic bypass;

    // Wrap explicitly at DEPTH-1 so non-power-of-two depths never index past the array.
    function automatic logic [IdxWidth-1:0] ptr_inc(input logic [IdxWidth-1:0] ptr);
        return (ptr == IdxWidth'(DEPTH - 1)) ? '0 : ptr + IdxWidth'(1);
    endfunction

    assign empty = (usage_q == '0);
    assign full  = (usage_q == CntWidth'(DEPTH));

    // ready_o depends only on registered state and clr_i, never on ready_i.
    assign ready_o = !full && !clr_i;

    always_comb begin
        valid_o = !empty && !clr_i;
        data_o  = storage[rptr_q];
        if (FALL_THROUGH && empty) begin
            valid_o = valid_i && !clr_i;
            data_o  = data_i;
        end
    end

    assign push   = valid_i && ready_o;
    assign pop    = valid_o && ready_i;
    assign bypass = FALL_THROUGH && empty && push && pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            usage_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            usage_q <= '0;
        end else if (!bypass) begin
            if (push) begin
                storage[wptr_q] <= data_i;
                wptr_q          <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (push && !pop) begin
                usage_q <= usage_q + CntWidth'(1);
            end else if (pop && !push) begin
                usage_q <= usage_q - CntWidth'(1);
            end
        end
    end

    assign usage_o     = usage_q;
    assign alm_full_o  = (usage_q >= CntWidth'(ALM_FULL_TH));
    assign alm_empty_o = (usage_q <= CntWidth'(ALM_EMPTY_TH));

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (int'(usage_q) <= DEPTH)
                else $error("stream_fifo_thresh: usage above DEPTH");
            assert (!(pop && empty) || bypass)
                else $error("stream_fifo_thresh: pop while empty");
            assert (((int'(wptr_q) + DEPTH - int'(rptr_q)) % DEPTH) == (int'(usage_q) % DEPTH))
                else $error("stream_fifo_thresh: pointer distance disagrees with usage");
        end
    end

endmodule

// File: tb/tb_stream_fifo_thresh.sv
// tb/tb_stream_fifo_thresh.sv - directed bench for stream_fifo_thresh, DEPTH=5 normal and fall-through
module tb_stream_fifo_thresh;

    logic       clk;
    logic       rst_n;

    logic       n_clr, n_valid, n_ready;
    logic [7:0] n_data;
    logic       n_ready_o, n_valid_o, n_af, n_ae;
    logic [7:0] n_data_o;
    logic [2:0] n_usage;

    logic       f_clr, f_valid, f_ready;
    logic [7:0] f_data;
    logic       f_ready_o, f_valid_o, f_af, f_ae;
    logic [7:0] f_data_o;
    logic [2:0] f_usage;

    int n_cmp = 0;
    int n_err = 0;

    stream_fifo_thresh #(
        .T(logic [7:0]), .DEPTH(5), .FALL_THROUGH(1'b0)
    ) u_norm (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(n_clr),
        .data_i(n_data), .valid_i(n_valid), .ready_o(n_ready_o),
        .data_o(n_data_o), .valid_o(n_valid_o), .ready_i(n_ready),
        .usage_o(n_usage), .alm_full_o(n_af), .alm_empty_o(n_ae)
    );

    stream_fifo_thresh #(
        .T(logic [7:0]), .DEPTH(5), .FALL_THROUGH(1'b1)
    ) u_ft (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(f_clr),
        .data_i(f_data), .valid_i(f_valid), .ready_o(f_ready_o),
        .data_o(f_data_o), .valid_o(f_valid_o), .ready_i(f_ready),
        .usage_o(f_usage), .alm_full_o(f_af), .alm_empty_o(f_ae)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
            else begin
                n_err++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] v;
        rst_n   = 1'b0;
        n_clr   = 1'b0; n_valid = 1'b0; n_ready = 1'b0; n_data = 8'h00;
        f_clr   = 1'b0; f_valid = 1'b1; f_ready = 1'b0; f_data = 8'h3C;

        // reset values
        #3;
        chk("rst_ready",   32'(n_ready_o), 32'd1);
        chk("rst_valid",   32'(n_valid_o), 32'd0);
        chk("rst_data",    32'(n_data_o),  32'h00);
        chk("rst_usage",   32'(n_usage),   32'd0);
        chk("rst_af",      32'(n_af),      32'd0);
        chk("rst_ae",      32'(n_ae),      32'd1);
        chk("rst_ft_valid", 32'(f_valid_o), 32'd1);
        chk("rst_ft_data",  32'(f_data_o),  32'h3C);
        f_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // fill 0x10..0x14
        for (int i = 0; i < 5; i++) begin
            n_valid = 1'b1;
            n_data  = 8'h10 + 8'(i);
            #1;
            chk("fill_ready_before", 32'(n_ready_o), 32'd1);
            tick();
            chk("fill_usage", 32'(n_usage), 32'(i + 1));
            chk("fill_af", 32'(n_af), (i + 1 >= 4) ? 32'd1 : 32'd0);
        end
        n_valid = 1'b0;
        chk("full_ready", 32'(n_ready_o), 32'd0);
        chk("full_head",  32'(n_data_o),  32'h10);

        // drain in order; alm_empty at usage 1 and 0
        n_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_valid", 32'(n_valid_o), 32'd1);
            chk("drain_data",  32'(n_data_o),  32'h10 + 32'(i));
            chk("drain_ae",    32'(n_ae),      (5 - i <= 1) ? 32'd1 : 32'd0);
            tick();
            if (i == 0) chk("ready_after_pop", 32'(n_ready_o), 32'd1);
        end
        n_ready = 1'b0;
        chk("drained_usage", 32'(n_usage),   32'd0);
        chk("drained_valid", 32'(n_valid_o), 32'd0);
        chk("drained_ae",    32'(n_ae),      32'd1);

        // wrap-around: 4 rounds of push 3 / pop 3
        v = 8'h20;
        for (int r = 0; r < 4; r++) begin
            n_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                n_data = v + 8'(r * 3 + i);
                tick();
            end
            n_valid = 1'b0;
            chk("wrap_usage", 32'(n_usage), 32'd3);
            n_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                chk("wrap_data", 32'(n_data_o), 32'(v) + 32'(r * 3 + i));
                tick();
            end
            n_ready = 1'b0;
        end
        chk("wrap_empty", 32'(n_usage), 32'd0);

        // simultaneous push/pop at usage 2
        n_valid = 1'b1;
        n_data = 8'h40; tick();
        n_data = 8'h41; tick();
        n_data = 8'h42; n_ready = 1'b1; tick();
        chk("pp_usage", 32'(n_usage),  32'd2);
        chk("pp_head",  32'(n_data_o), 32'h41);
        n_ready = 1'b0;
        n_data = 8'h43; tick();
        n_data = 8'h44; tick();
        n_data = 8'h45; tick();
        chk("pp_full", 32'(n_usage), 32'd5);
        // full: pop accepted, push refused
        n_data = 8'h46; n_ready = 1'b1;
        #1;
        chk("full_pp_ready", 32'(n_ready_o), 32'd0);
        tick();
        chk("full_pp_usage", 32'(n_usage),  32'd4);
        chk("full_pp_head",  32'(n_data_o), 32'h42);
        n_valid = 1'b0;
        tick();
        n_ready = 1'b0;
        chk("pre_clr_usage", 32'(n_usage),  32'd3);
        chk("pre_clr_head",  32'(n_data_o), 32'h43);

        // clear during a handshake
        n_clr = 1'b1; n_valid = 1'b1; n_ready = 1'b1; n_data = 8'h60;
        #1;
        chk("clr_ready", 32'(n_ready_o), 32'd0);
        chk("clr_valid", 32'(n_valid_o), 32'd0);
        tick();
        n_clr = 1'b0; n_valid = 1'b0; n_ready = 1'b0;
        #1;
        chk("clr_usage",   32'(n_usage),   32'd0);
        chk("clr_valid_n", 32'(n_valid_o), 32'd0);
        chk("clr_ae",      32'(n_ae),      32'd1);

        // asynchronous reset at usage 4
        n_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_data = 8'h50 + 8'(i);
            tick();
        end
        chk("pre_rst_usage", 32'(n_usage), 32'd4);
        n_data = 8'h99; n_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_usage", 32'(n_usage),   32'd0);
        chk("arst_valid", 32'(n_valid_o), 32'd0);
        chk("arst_ready", 32'(n_ready_o), 32'd1);
        chk("arst_data",  32'(n_data_o),  32'h00);
        chk("arst_ae",    32'(n_ae),      32'd1);
        tick();
        chk("arst_hold_usage", 32'(n_usage), 32'd0);
        n_valid = 1'b0; n_ready = 1'b0;
        rst_n = 1'b1;
        n_valid = 1'b1; n_data = 8'h77;
        tick();
        n_valid = 1'b0;
        chk("post_rst_valid", 32'(n_valid_o), 32'd1);
        chk("post_rst_data",  32'(n_data_o),  32'h77);
        n_ready = 1'b1;
        tick();
        n_ready = 1'b0;
        chk("post_rst_usage", 32'(n_usage), 32'd0);

        // fall-through bypass on empty FIFO
        f_valid = 1'b1; f_data = 8'hA5; f_ready = 1'b1;
        #1;
        chk("ft_valid", 32'(f_valid_o), 32'd1);
        chk("ft_data",  32'(f_data_o),  32'hA5);
        chk("ft_ready", 32'(f_ready_o), 32'd1);
        tick();
        chk("ft_usage", 32'(f_usage), 32'd0);
        // fall-through with a stored entry behaves like a normal FIFO
        f_data = 8'hB6; f_ready = 1'b0;
        tick();
        chk("ft_store_usage", 32'(f_usage),  32'd1);
        chk("ft_store_data",  32'(f_data_o), 32'hB6);
        f_data = 8'hC7; f_ready = 1'b1;
        #1;
        chk("ft_nb_data", 32'(f_data_o), 32'hB6);
        tick();
        chk("ft_nb_usage", 32'(f_usage),  32'd1);
        chk("ft_nb_head",  32'(f_data_o), 32'hC7);
        f_valid = 1'b0;
        tick();
        f_ready = 1'b0;
        chk("ft_end_usage", 32'(f_usage), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
